// File: rtl/uart_bridge_pkg.sv
// Shared constants and types for the UART FIFO bridge: bus offsets, status bit
// positions and the transmit sequencer state encoding.
package uart_bridge_pkg;

    localparam logic [3:0] UART_DATA_OFS = 4'h8;
    localparam logic [3:0] UART_STAT_OFS = 4'hC;

    localparam int STAT_TX_NFULL  = 0;
    localparam int STAT_RX_NEMPTY = 1;
    localparam int STAT_TX_OVF    = 2;
    localparam int STAT_RX_OVF    = 3;

    // Bit in a status write that clears both sticky overflow flags.
    localparam int STAT_CLR_BIT   = 7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_t;

    function automatic logic [31:0] pack_status(input logic tx_nfull,
                                                input logic rx_nempty,
                                                input logic tx_ovf,
                                                input logic rx_ovf);
        logic [31:0] s;
        s                 = '0;
        s[STAT_TX_NFULL]  = tx_nfull;
        s[STAT_RX_NEMPTY] = rx_nempty;
        s[STAT_TX_OVF]    = tx_ovf;
        s[STAT_RX_OVF]    = rx_ovf;
        return s;
    endfunction

endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an extra pointer bit for
// full/empty; a push while full is only accepted alongside a pop.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic                do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign dout  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Buffered bridge between the CPU serial window and the UART cores.
// Build option UART_BRIDGE_LOOPBACK_EN routes transmitted bytes back into the RX FIFO.
//
// state     | meaning
// IDLE      | waiting for a queued byte and an idle transmitter
// START     | holding tx_start_o for START_HOLD cycles
// WAIT_DONE | waiting for the transmitter to drop busy
module uart_fifo_bridge
    import uart_bridge_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int START_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [3:0]  bus_addr_i,
    input  logic [7:0]  bus_data_i,
    output logic [31:0] bus_data_o,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_ready_i,
    input  logic        tx_busy_i,
    output logic        tx_start_o,
    output logic [7:0]  tx_data_o,
    output logic        rx_int_o
);

    tx_state_t  state_q, state_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       tx_ovf_q, tx_ovf_d;
    logic       rx_ovf_q, rx_ovf_d;
    logic       rx_int_q, rx_int_d;

    logic       data_wr, data_rd, stat_clr;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_head;
    logic       rx_push_req, rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_head, rx_din;
    logic       lb_push;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (bus_data_i),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_din),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_comb begin
        data_wr  = bus_req_i &  bus_we_i & (bus_addr_i == UART_DATA_OFS);
        data_rd  = bus_req_i & ~bus_we_i & (bus_addr_i == UART_DATA_OFS);
        stat_clr = bus_req_i &  bus_we_i & (bus_addr_i == UART_STAT_OFS) &
                   bus_data_i[STAT_CLR_BIT];
        tx_push  = data_wr & ~tx_full;
        rx_pop   = data_rd & ~rx_empty;
    end

`ifdef UART_BRIDGE_LOOPBACK_EN
    logic unused_lb;
    assign unused_lb   = ^{tx_busy_i, rx_ready_i, rx_data_i};
    assign rx_push_req = lb_push;
    assign rx_din      = tx_head;
`else
    assign rx_push_req = rx_ready_i;
    assign rx_din      = rx_data_i;
`endif

    // A full RX FIFO still takes the byte when a read frees a slot this cycle.
    always_comb begin
        rx_push  = rx_push_req & (~rx_full | rx_pop);
        tx_ovf_d = (tx_ovf_q & ~stat_clr) | (data_wr & tx_full);
        rx_ovf_d = (rx_ovf_q & ~stat_clr) | (rx_push_req & rx_full & ~rx_pop);
        rx_int_d = ~rx_empty;
    end

    always_comb begin
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        hold_cnt_d = hold_cnt_q;
        tx_pop     = 1'b0;
        lb_push    = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef UART_BRIDGE_LOOPBACK_EN
                if (!tx_empty) begin
                    tx_pop    = 1'b1;
                    lb_push   = 1'b1;
                    tx_data_d = tx_head;
                    state_d   = WAIT_DONE;
                end
`else
                if (!tx_empty && !tx_busy_i) begin
                    tx_pop     = 1'b1;
                    tx_data_d  = tx_head;
                    tx_start_d = 1'b1;
                    hold_cnt_d = 4'(START_HOLD - 1);
                    state_d    = START;
                end
`endif
            end
            START: begin
                if (hold_cnt_q == 4'd0) begin
                    tx_start_d = 1'b0;
                    state_d    = WAIT_DONE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            WAIT_DONE: begin
`ifdef UART_BRIDGE_LOOPBACK_EN
                state_d = IDLE;
`else
                if (!tx_busy_i) begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d    = IDLE;
                tx_start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            hold_cnt_q <= 4'd0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            rx_int_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            hold_cnt_q <= hold_cnt_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovf_q   <= rx_ovf_d;
            rx_int_q   <= rx_int_d;
        end
    end

    always_comb begin
        bus_data_o = 32'h0;
        if (bus_addr_i == UART_DATA_OFS) begin
            if (!rx_empty) begin
                bus_data_o = {24'h0, rx_head};
            end
        end else if (bus_addr_i == UART_STAT_OFS) begin
            bus_data_o = pack_status(~tx_full, ~rx_empty, tx_ovf_q, rx_ovf_q);
        end
    end

    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign rx_int_o   = rx_int_q;

endmodule

// File: doc/uart_fifo_bridge.md
# uart_fifo_bridge

Buffered serial-port controller between the CPU data-bus serial window and the async UART transmitter/receiver cores. It replaces direct, unbuffered byte handoff with a TX FIFO, an RX FIFO and a transmit sequencer that generates a properly held start strobe. It also exposes a status word and a receive interrupt. It sits downstream of the board-level bus multiplexer and upstream of the UART cores; all logic is in one clock domain with the cores.

## Interface
- DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries)
- START_HOLD, 4, cycles tx_start_o stays high per byte (1..15)
- clk  in  1  system clock; the UART cores run on the same clock
- rst  in  1  reset, synchronous, active-high
- bus_req_i  in  1  single-cycle access strobe for the serial window
- bus_we_i  in  1  1 = write, 0 = read; valid with bus_req_i
- bus_addr_i  in  4  byte offset: 0x8 = data, 0xC = status
- bus_data_i  in  8  write data
- bus_data_o  out  32  read data, combinational from bus_addr_i
- rx_data_i  in  8  receiver byte
- rx_ready_i  in  1  receiver byte-valid, one-cycle pulse
- tx_busy_i  in  1  transmitter busy
- tx_start_o  out  1  transmitter start
- tx_data_o  out  8  transmitter byte, stable while tx_start_o is high
- rx_int_o  out  1  interrupt: RX FIFO not empty (registered)

## Operation
- Status word layout:
  - bit0: TX FIFO not full
  - bit1: RX FIFO not empty
  - bit2: TX overflow (sticky)
  - bit3: RX overflow (sticky)
  - bits[31:4]: 0
- Write to status with bus_data_i[7] = 1 clears both sticky bits; all other status writes are ignored.
- Data write pushes bus_data_i into the TX FIFO. If the TX FIFO is full, the byte is dropped and the TX overflow bit is set.
- Data read returns {24'b0, RX head}, and bus_req_i pops the head. If the RX FIFO is empty, the read returns 0 and no pop occurs.
- Offsets other than 0x8/0xC: reads return 0, writes are ignored.
- rx_ready_i pushes rx_data_i into the RX FIFO. If the RX FIFO is full with no simultaneous pop, the byte is dropped and the RX overflow bit is set. Full with a simultaneous pop: both the pop and the push occur and the count is unchanged.
- TX FIFO push and pop in the same cycle are both honoured.
- TX sequencer states:
  - IDLE: if the TX FIFO is non-empty and tx_busy_i = 0, pop into tx_data_o and go to START.
  - START: tx_start_o = 1 for START_HOLD cycles, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_busy_i = 0, then go to IDLE.
- Reset mid-operation returns to IDLE, empties both FIFOs and clears the sticky bits. A byte already handed to the transmitter is not recalled.

## Timing
- Reset values: tx_start_o = 0, tx_data_o = 0, rx_int_o = 0; bus_data_o evaluates to 0 at the status offset except bit0 = 1.
- Write-to-start latency, with an empty FIFO and the transmitter idle:
  - push at edge N
  - IDLE pops at edge N+1
  - tx_start_o high from N+1 through N+START_HOLD
- Back-to-back bytes: the next start follows no earlier than 1 cycle after tx_busy_i falls.
- rx_int_o rises 2 cycles after the rx_ready_i edge: push at +1, register at +2.
- FIFO pointers wrap modulo 2^DEPTH_LOG2; full/empty use an extra pointer bit.

## Configuration
- UART_BRIDGE_LOOPBACK_EN defined:
  - The IDLE pop pushes the TX byte straight into the RX FIFO; tx_busy_i is not checked; the sequencer returns to IDLE the next cycle.
  - tx_start_o is held 0; rx_ready_i is ignored.
  - Overflow rules are unchanged.
- UART_BRIDGE_LOOPBACK_EN undefined: normal operation as above.

## Structure
- Package uart_bridge_pkg holds:
  - offset constants: UART_DATA_OFS = 4'h8, UART_STAT_OFS = 4'hC
  - status bit indices
  - tx_state_t enum: IDLE, START, WAIT_DONE
- One sub-module, sync_fifo:
  - parameterised width and DEPTH_LOG2
  - ports: push, pop, din, dout (head, first-word-fall-through), full, empty
  - instantiated twice

## Test plan
- Reset, then read status -> 0x00000001; tx_start_o = 0; rx_int_o = 0.
- Write 0x41, 0x42 with tx_busy_i modelled as 10 cycles high after start -> two start pulses of exactly 4 cycles each, carrying 0x41 then 0x42, the second starting after busy falls.
- Write 17 bytes with tx_busy_i held high -> status = 0x00000004 (TX full, overflow set); write status 0x80 -> bit2 clears.
- Pulse rx_ready_i with 0x55 -> rx_int_o high 2 cycles later; data read returns 0x00000055; status bit1 then reads 0.
- With the RX FIFO full, pulse rx_ready_i (0xAA) in the same cycle as a data read -> the read returns the old head, the count stays 16 and the overflow bit stays 0.
- With UART_BRIDGE_LOOPBACK_EN defined, write 0x3C -> a data read 3 cycles later returns 0x3C and tx_start_o never asserts.
